xmas_light_seq: RTL and testbench
=================================

Name: xmas_light_seq

Overview:
- Parametrised successor to the two-light Christmas-tree FSM. Drives N_LIGHTS independent lamps through selectable animation modes.
- An internal prescaler paces the pattern steps.
- Sits between the board clock/switch inputs and the LED pins.
- All outputs are registered.

Parameters:
- N_LIGHTS, 4, number of lamp outputs; legal range 2..16.
- TICK_DIV, 4, clock cycles per pattern step; legal range >= 1.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- en  input  1  advance enable; low freezes prescaler and pattern.
- mode  input  2  requested animation mode: 00 BLINK, 01 CHASE, 10 PINGPONG, 11 SPARKLE.
- lights  output  N_LIGHTS  lamp drive; bit i = lamp i on.
- step  output  1  one-cycle pulse, high in the cycle after lights updates.
- mode_act  output  2  mode currently being animated.

Behaviour:
- Interface: one clock `clk`; reset is synchronous and active-high on port `reset`.
- Reset values: lights=0, step=0, mode_act=BLINK, prescaler cnt=0, blink phase=off, pingpong dir=up, LFSR=16'hACE1.
- Reset asserted mid-pattern wins over all other activity on that edge.
- Prescaler: cnt counts 0..TICK_DIV-1 while en=1 and wraps to 0. The step event is en=1 && cnt==TICK_DIV-1.
  - TICK_DIV=1: step event on every enabled cycle.
  - en=0: cnt, lights, mode_act and LFSR all hold; step=0.
- First update: with en held high after reset release, the first lights change occurs at edge number TICK_DIV.
- Mode sampling: mode is sampled only on step events. Between steps, changes on mode are ignored.
- Mode switch: on a step event with mode != mode_act, mode_act<=mode and lights load the new mode's initial pattern instead of advancing. Initial patterns:
  - BLINK: all-ones, phase=on.
  - CHASE: one-hot bit0.
  - PINGPONG: one-hot bit0, dir=up.
  - SPARKLE: current LFSR low N bits.
- Advance on a step event with the mode unchanged:
  - BLINK: lights toggle between 0 and all-ones. After reset, the first step gives all-ones.
  - CHASE: rotate left; bit N_LIGHTS-1 wraps to bit0. If lights==0 on entry (e.g. after reset), load bit0.
  - PINGPONG: one-hot bounce 0,1,..,N-1,N-2,..,1,0,1... Each endpoint is shown exactly once per traversal. Direction flips when the lit bit reaches N-1 (going up) or 0 (going down). If lights==0, load bit0 with dir=up.
  - SPARKLE: see Optional Feature.
- step: registered; high exactly one cycle, in the cycle immediately following each step event, including mode-switch steps.
- No combinational path exists from inputs to outputs.

Optional Feature:
- Macro: XMAS_SPARKLE_EN.
- Defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1; never zero) advances on every step event in any mode. In SPARKLE mode, lights = LFSR[N_LIGHTS-1:0] after the advance.
- Undefined: no LFSR is built. mode=11 is treated as BLINK: mode_act reports 00 and the BLINK sequence is produced.

Decomposition:
- Package xmas_pkg holds:
  - typedef enum logic [1:0] mode_t {BLINK, CHASE, PINGPONG, SPARKLE};
  - LFSR_SEED = 16'hACE1;
  - LFSR_TAPS constant.
- Sub-module xmas_tick_prescaler (parameter TICK_DIV; ports clk, reset, en, tick) isolates the counter.
- The pattern FSM stays in xmas_light_seq.

Test Plan:
- Reset then en=1, mode=00, N=4, TICK_DIV=4 -> lights 0000 for 4 cycles, then 1111, 0000, 1111 every 4 cycles; step pulses one cycle after each change.
- mode=01 from reset -> first step gives mode_act=01, lights=0001, then 0010, 0100, 1000, 0001 (wrap).
- mode=10 -> lights 0001,0010,0100,1000,0100,0010,0001,0010 on successive steps; each endpoint appears once.
- CHASE at 0100, en dropped for 10 cycles, then raised -> lights hold 0100 and step stays 0 while low. Next change occurs TICK_DIV-cnt_at_freeze cycles after en rises.
- In CHASE, mode toggled 01->10->01 between steps -> ignored, no switch. mode=10 held across a step -> lights=0001 on that step. Reset asserted mid-PINGPONG -> next cycle lights=0000, mode_act=00, step=0.
- XMAS_SPARKLE_EN defined, mode=11 -> lights equal the low 4 bits of the reference LFSR sequence from seed ACE1 and are never stuck. Undefined: mode=11 -> mode_act=00 and the BLINK sequence.

Source files
------------

// File: rtl/xmas_pkg.sv
// Shared types and constants for the Christmas light sequencer.
// The LFSR is only used when XMAS_SPARKLE_EN is defined.
package xmas_pkg;

    typedef enum logic [1:0] {
        BLINK    = 2'b00,
        CHASE    = 2'b01,
        PINGPONG = 2'b10,
        SPARKLE  = 2'b11
    } mode_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Right-shift Fibonacci form of x^16 + x^14 + x^13 + x^11 + 1.
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {^(s & LFSR_TAPS), s[15:1]};
    endfunction

endpackage

// File: rtl/xmas_tick_prescaler.sv
// Pattern-step prescaler: counts 0..TICK_DIV-1 while enabled.
// It pulses tick combinationally on the last count of each period.
module xmas_tick_prescaler #(
    parameter int TICK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/xmas_light_seq.sv
// N-lamp animation sequencer (blink / chase / ping-pong / sparkle).
// Define XMAS_SPARKLE_EN to build the LFSR sparkle mode; otherwise mode 11 acts as BLINK.
module xmas_light_seq
    import xmas_pkg::*;
#(
    parameter int N_LIGHTS = 4,
    parameter int TICK_DIV = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic [1:0]          mode,
    output logic [N_LIGHTS-1:0] lights,
    output logic                step,
    output logic [1:0]          mode_act
);

    localparam logic [N_LIGHTS-1:0] ONE = {{(N_LIGHTS-1){1'b0}}, 1'b1};

    logic                tick;
    mode_t               mode_q, mode_d, req;
    logic [N_LIGHTS-1:0] lights_d;
    logic                phase_q, phase_d;
    logic                dir_up_q, dir_up_d;
`ifdef XMAS_SPARKLE_EN
    logic [15:0]         lfsr_q, lfsr_d;
`endif

    xmas_tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .tick  (tick)
    );

    assign mode_act = mode_q;

    always_comb begin
        mode_d   = mode_q;
        lights_d = lights;
        phase_d  = phase_q;
        dir_up_d = dir_up_q;
        req      = mode_t'(mode);
`ifdef XMAS_SPARKLE_EN
        lfsr_d   = lfsr_q;
`else
        if (req == SPARKLE) req = BLINK;
`endif
        if (tick) begin
`ifdef XMAS_SPARKLE_EN
            lfsr_d = lfsr_next(lfsr_q);
`endif
            if (req != mode_q) begin
                // A mode change loads the new mode's starting frame instead of advancing.
                mode_d = req;
                case (req)
                    BLINK: begin
                        lights_d = '1;
                        phase_d  = 1'b1;
                    end
                    CHASE:    lights_d = ONE;
                    PINGPONG: begin
                        lights_d = ONE;
                        dir_up_d = 1'b1;
                    end
                    SPARKLE: begin
`ifdef XMAS_SPARKLE_EN
                        lights_d = lfsr_q[N_LIGHTS-1:0];
`else
                        lights_d = '1;
`endif
                    end
                endcase
            end else begin
                case (mode_q)
                    BLINK: begin
                        phase_d  = ~phase_q;
                        lights_d = phase_q ? '0 : '1;
                    end
                    CHASE: lights_d = (lights == '0) ? ONE
                                                     : {lights[N_LIGHTS-2:0], lights[N_LIGHTS-1]};
                    PINGPONG: begin
                        if (lights == '0) begin
                            lights_d = ONE;
                            dir_up_d = 1'b1;
                        end else if (dir_up_q) begin
                            if (lights[N_LIGHTS-1]) begin
                                lights_d = lights >> 1;
                                dir_up_d = 1'b0;
                            end else begin
                                lights_d = lights << 1;
                            end
                        end else begin
                            if (lights[0]) begin
                                lights_d = lights << 1;
                                dir_up_d = 1'b1;
                            end else begin
                                lights_d = lights >> 1;
                            end
                        end
                    end
                    SPARKLE: begin
`ifdef XMAS_SPARKLE_EN
                        lights_d = lfsr_d[N_LIGHTS-1:0];
`else
                        lights_d = lights;
`endif
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lights   <= '0;
            step     <= 1'b0;
            mode_q   <= BLINK;
            phase_q  <= 1'b0;
            dir_up_q <= 1'b1;
`ifdef XMAS_SPARKLE_EN
            lfsr_q   <= LFSR_SEED;
`endif
        end else begin
            lights   <= lights_d;
            step     <= tick;
            mode_q   <= mode_d;
            phase_q  <= phase_d;
            dir_up_q <= dir_up_d;
`ifdef XMAS_SPARKLE_EN
            lfsr_q   <= lfsr_d;
`endif
        end
    end

endmodule

// File: tb/tb_xmas_light_seq.sv
// Self-checking bench for xmas_light_seq (N_LIGHTS=4, TICK_DIV=4).
// Honours XMAS_SPARKLE_EN the same way as the design.
module tb_xmas_light_seq;

    localparam int N  = 4;
    localparam int TD = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         en = 1'b0;
    logic [1:0]   mode = 2'b00;
    logic [N-1:0] lights;
    logic         step;
    logic [1:0]   mode_act;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    xmas_light_seq #(.N_LIGHTS(N), .TICK_DIV(TD)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .mode     (mode),
        .lights   (lights),
        .step     (step),
        .mode_act (mode_act)
    );

    // Model: mode plus a frame counter since mode entry; lights derived arithmetically.
    int          m_cnt, m_pos, m_mode, m_req;
    bit          m_step, m_valid = 0, m_sw;
    logic [15:0] m_lfsr, m_spark, m_prev;

    function automatic logic [15:0] ref_lfsr(input logic [15:0] s);
        logic b;
        b = s[0] ^ s[2] ^ s[3] ^ s[5];
        return (s >> 1) | (16'(b) << 15);
    endfunction

    function automatic logic [N-1:0] model_lights();
        int p, idx;
        case (m_mode)
            0: return (m_pos < 0 || (m_pos % 2) == 1) ? '0 : '1;
            1: return N'(1) << (m_pos % N);
            2: begin
                p   = m_pos % (2 * N - 2);
                idx = (p < N) ? p : (2 * N - 2 - p);
                return N'(1) << idx;
            end
            default: return m_spark[N-1:0];
        endcase
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_valid = 1;
            m_cnt   = 0;
            m_mode  = 0;
            m_pos   = -1;
            m_step  = 0;
            m_lfsr  = 16'hACE1;
            m_spark = 16'h0;
        end else if (!en) begin
            m_step = 0;
        end else begin
            m_step = (m_cnt == TD - 1);
            m_cnt  = (m_cnt + 1) % TD;
            if (m_step) begin
                m_req = int'(mode);
`ifndef XMAS_SPARKLE_EN
                if (m_req == 3) m_req = 0;
`endif
                m_sw   = (m_req != m_mode);
                m_prev = m_lfsr;
`ifdef XMAS_SPARKLE_EN
                m_lfsr = ref_lfsr(m_lfsr);
`endif
                if (m_sw) begin
                    m_mode  = m_req;
                    m_pos   = 0;
                    m_spark = m_prev;
                end else begin
                    m_pos   = m_pos + 1;
                    m_spark = m_lfsr;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            checks++;
            if (lights !== model_lights() || step !== m_step || mode_act !== 2'(m_mode)) begin
                errors++;
                $display("FAIL model t=%0t lights got %b exp %b step got %b exp %b mode_act got %0d exp %0d",
                         $time, lights, model_lights(), step, m_step, mode_act, m_mode);
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got %h exp %h", name, $time, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic [3:0] pp_seq [7] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};

    initial begin
        cyc(2);
        chk("reset_lights", 16'(lights), 16'h0);
        chk("reset_mode_act", 16'(mode_act), 16'h0);
        chk("reset_step", 16'(step), 16'h0);

        reset = 1'b0;
        en    = 1'b1;
        cyc(3);
        chk("blink_before_first", 16'(lights), 16'h0);
        cyc(1);
        chk("blink_first_on", 16'(lights), 16'hF);
        chk("blink_first_step", 16'(step), 16'h1);
        cyc(1);
        chk("step_one_cycle", 16'(step), 16'h0);
        cyc(3);
        chk("blink_off", 16'(lights), 16'h0);

        mode = 2'b01;
        cyc(4);
        chk("chase_switch", 16'(lights), 16'h1);
        chk("chase_mode_act", 16'(mode_act), 16'h1);
        cyc(4);
        chk("chase_1", 16'(lights), 16'h2);
        cyc(4);
        chk("chase_2", 16'(lights), 16'h4);

        cyc(2);
        en = 1'b0;
        cyc(10);
        chk("freeze_lights", 16'(lights), 16'h4);
        chk("freeze_step", 16'(step), 16'h0);
        en = 1'b1;
        cyc(1);
        chk("resume_hold", 16'(lights), 16'h4);
        cyc(1);
        chk("resume_advance", 16'(lights), 16'h8);
        chk("resume_step", 16'(step), 16'h1);

        mode = 2'b10;
        cyc(1);
        mode = 2'b01;
        cyc(3);
        chk("glitch_ignored_wrap", 16'(lights), 16'h1);
        chk("glitch_mode_act", 16'(mode_act), 16'h1);

        mode = 2'b10;
        cyc(4);
        chk("pp_switch", 16'(lights), 16'h1);
        chk("pp_mode_act", 16'(mode_act), 16'h2);
        for (int i = 0; i < 7; i++) begin
            cyc(4);
            chk("pp_seq", 16'(lights), 16'(pp_seq[i]));
        end

        cyc(2);
        reset = 1'b1;
        cyc(1);
        chk("midreset_lights", 16'(lights), 16'h0);
        chk("midreset_mode_act", 16'(mode_act), 16'h0);
        chk("midreset_step", 16'(step), 16'h0);

        reset = 1'b0;
        mode  = 2'b11;
        cyc(4);
`ifdef XMAS_SPARKLE_EN
        chk("sparkle_first", 16'(lights), 16'h1);
        chk("sparkle_mode_act", 16'(mode_act), 16'h3);
        cyc(4);
        chk("sparkle_second", 16'(lights), 16'h8);
`else
        chk("mode3_blink_on", 16'(lights), 16'hF);
        chk("mode3_mode_act", 16'(mode_act), 16'h0);
        cyc(4);
        chk("mode3_blink_off", 16'(lights), 16'h0);
`endif
        cyc(60);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
